// File: rtl/mem_backing_model.sv
// Line-granular main-memory model behind the direct-mapped cache controller.
// Accepts one request at a time, answers after a fixed DELAY, stores whole
// 256-bit lines and counts completed reads and writes for bandwidth checks.
module mem_backing_model #(
  parameter int DELAY = 100,
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  mem_req_addr,
  input  logic [255:0] mem_req_data,
  input  logic         mem_req_rw,
  input  logic         mem_req_valid,
  output logic [255:0] mem_data,
  output logic         mem_ready,
  output logic         busy,
  output logic         oob_err,
  output logic [31:0]  rd_count,
  output logic [31:0]  wr_count
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  // Counter load value; zero means the cycle after acceptance is already RESPOND.
  localparam logic [15:0] LOAD = 16'(DELAY - 1);

  state_t         r_state;
  state_t         w_next;
  logic [15:0]    r_cnt;
  logic [AW-1:0]  r_idx;
  logic [255:0]   r_wdata;
  logic           r_rw;
  logic           r_oob;
  logic [255:0]   r_mem [0:DEPTH-1];
  logic [255:0]   r_rdata;
  logic [31:0]    r_rd_cnt;
  logic [31:0]    r_wr_cnt;

  logic [AW-1:0]  w_req_idx;
  logic           w_req_oob;
  logic           w_accept;
  logic           w_enter_resp;
  logic [AW-1:0]  w_rd_idx;
  logic           w_rd_oob;
  logic           w_rd_rw;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Byte offset bits are dropped; any set bit above the index field is out of range.
  assign w_req_idx = mem_req_addr[AW+4:5];
  assign w_req_oob = (32'(w_req_idx) >= 32'(DEPTH)) || ((mem_req_addr >> (AW + 5)) != 32'd0);
  assign w_accept  = (r_state == S_IDLE) && mem_req_valid;

  // When DELAY is 1 the array is read on the acceptance edge, so use the live request.
  assign w_rd_idx     = (r_state == S_IDLE) ? w_req_idx  : r_idx;
  assign w_rd_oob     = (r_state == S_IDLE) ? w_req_oob  : r_oob;
  assign w_rd_rw      = (r_state == S_IDLE) ? mem_req_rw : r_rw;
  assign w_enter_resp = (w_next == S_RESP) && (r_state != S_RESP);

  // State register; reset abandons any pending request.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode: WAIT leaves when the countdown is about to reach zero.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (mem_req_valid) w_next = (LOAD == 16'd0) ? S_RESP : S_WAIT;
      S_WAIT:  if (r_cnt == 16'd1) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Capture the request on acceptance and count down while waiting.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_cnt   <= LOAD;
      r_idx   <= w_req_idx;
      r_wdata <= mem_req_data;
      r_rw    <= mem_req_rw;
      r_oob   <= w_req_oob;
    end else if (r_state == S_WAIT) begin
      r_cnt <= r_cnt - 16'd1;
    end
  end

  // Read line is registered on the edge entering RESPOND; writes leave it untouched.
  always_ff @(posedge clk) begin
    if (rst)                          r_rdata <= '0;
    else if (w_enter_resp && !w_rd_rw) r_rdata <= w_rd_oob ? '0 : r_mem[w_rd_idx];
  end

  // Line array: in-range writes commit at the end of RESPOND; never cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst && (r_state == S_RESP) && r_rw && !r_oob) r_mem[r_idx] <= r_wdata;
  end

  // Traffic counters, including out-of-range requests, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else if (r_state == S_RESP) begin
      if (r_rw) r_wr_cnt <= sat_inc(r_wr_cnt);
      else      r_rd_cnt <= sat_inc(r_rd_cnt);
    end
  end

  assign mem_data  = r_rdata;
  assign mem_ready = (r_state == S_RESP);
  assign busy      = (r_state != S_IDLE);
  assign oob_err   = (r_state == S_RESP) && r_oob;
  assign rd_count  = r_rd_cnt;
  assign wr_count  = r_wr_cnt;

endmodule

// File: tb/tb_mem_backing_model.sv
// Bench for mem_backing_model: main instance with DELAY=4 plus DELAY=1 and
// DELAY=100 instances for latency checks; reference is a line-keyed array.
module tb_mem_backing_model;
  localparam int D = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, rw, valid;
  logic [31:0]  addr;
  logic [255:0] wdata;
  logic [255:0] mem_data;
  logic         ready, busy, oob;
  logic [31:0]  rd_cnt, wr_cnt;

  logic         x_rst, x_rw, x_valid1, x_valid100;
  logic [31:0]  x_addr;
  logic [255:0] x_wdata;
  logic [255:0] d1_data, d100_data;
  logic         d1_ready, d1_busy, d1_oob, d100_ready, d100_busy, d100_oob;
  logic [31:0]  d1_rd, d1_wr, d100_rd, d100_wr;

  mem_backing_model #(.DELAY(D), .DEPTH(1024), .AW(10)) u_dut (
    .clk(clk), .rst(rst), .mem_req_addr(addr), .mem_req_data(wdata), .mem_req_rw(rw),
    .mem_req_valid(valid), .mem_data(mem_data), .mem_ready(ready), .busy(busy),
    .oob_err(oob), .rd_count(rd_cnt), .wr_count(wr_cnt));

  mem_backing_model #(.DELAY(1), .DEPTH(1024), .AW(10)) u_d1 (
    .clk(clk), .rst(x_rst), .mem_req_addr(x_addr), .mem_req_data(x_wdata), .mem_req_rw(x_rw),
    .mem_req_valid(x_valid1), .mem_data(d1_data), .mem_ready(d1_ready), .busy(d1_busy),
    .oob_err(d1_oob), .rd_count(d1_rd), .wr_count(d1_wr));

  mem_backing_model #(.DELAY(100), .DEPTH(1024), .AW(10)) u_d100 (
    .clk(clk), .rst(x_rst), .mem_req_addr(x_addr), .mem_req_data(x_wdata), .mem_req_rw(x_rw),
    .mem_req_valid(x_valid100), .mem_data(d100_data), .mem_ready(d100_ready), .busy(d100_busy),
    .oob_err(d100_oob), .rd_count(d100_rd), .wr_count(d100_wr));

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [255:0] mdl [int];
  logic [31:0]  m_rd, m_wr;
  logic [255:0] m_data;
  logic [255:0] d0_line, p_line;
  bit           known [16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rnd256();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Apply one completed request to the reference; returns expected mem_data and oob flag.
  task automatic mdl_do(input logic [31:0] a, input logic [255:0] d, input logic w,
                        output logic [255:0] ed, output logic eo);
    int line;
    line = int'(a / 32);
    eo = (line >= 1024);
    if (w) begin
      if (m_wr != 32'hFFFF_FFFF) m_wr = m_wr + 1;
      if (!eo) mdl[line] = d;
    end else begin
      if (m_rd != 32'hFFFF_FFFF) m_rd = m_rd + 1;
      m_data = eo ? '0 : mdl[line];
    end
    ed = m_data;
  endtask

  // Drive one request; report edges until busy rises, busy-to-ready span, busy count, response.
  task automatic xact(input logic [31:0] a, input logic [255:0] d, input logic w, input bit hold,
                      output int wait_e, output int lat, output int nbusy,
                      output logic [255:0] rd, output logic oe);
    addr = a; wdata = d; rw = w; valid = 1'b1;
    wait_e = -1; lat = -1; nbusy = 0; rd = 'x; oe = 1'bx;
    for (int i = 1; i <= D + 20; i++) begin
      step();
      if (busy) begin
        nbusy++;
        if (wait_e < 0) wait_e = i;
      end
      if (ready) begin
        lat = (wait_e < 0) ? 0 : i - wait_e + 1;
        rd = mem_data;
        oe = oob;
        break;
      end
    end
    if (!hold) begin valid = 1'b0; rw = 1'b0; end
  endtask

  task automatic test_reset();
    int n;
    logic [255:0] ed; logic eo;
    d0_line = rnd256();
    rst = 1'b1; valid = 1'b1; rw = 1'b1; addr = 32'h0; wdata = d0_line;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ({busy, ready, oob, rd_cnt, wr_cnt, mem_data} !== '0) begin
        bad++; $display("FAIL reset_state busy=%b ready=%b oob=%b rd=%0d wr=%0d data=%h", busy, ready, oob, rd_cnt, wr_cnt, mem_data);
      end
    end
    rst = 1'b0;
    step();
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL first_accept busy=%b exp=1", busy); end
    n = 1;
    while (!ready && n < 20) begin step(); n++; end
    total++;
    if (n !== D) begin bad++; $display("FAIL reset_release_latency got=%0d exp=%0d", n, D); end
    valid = 1'b0; rw = 1'b0;
    mdl_do(32'h0, d0_line, 1'b1, ed, eo);
    known[0] = 1;
    step();
    total++;
    if ({busy, wr_cnt, rd_cnt} !== {1'b0, m_wr, m_rd}) begin
      bad++; $display("FAIL reset_first_write busy=%b wr=%0d rd=%0d exp wr=%0d rd=%0d", busy, wr_cnt, rd_cnt, m_wr, m_rd);
    end
  endtask

  task automatic test_write_read();
    int we, lat, nb; logic [255:0] rd, ed; logic oe, eo;
    logic [255:0] a5;
    a5 = {32{8'hA5}};
    mdl_do(32'h40, a5, 1'b1, ed, eo);
    xact(32'h40, a5, 1'b1, 0, we, lat, nb, rd, oe);
    known[2] = 1;
    total++;
    if ({we, lat, nb} !== {32'sd1, 32'(D), 32'(D)}) begin
      bad++; $display("FAIL wr_timing wait=%0d lat=%0d busy=%0d exp 1/%0d/%0d", we, lat, nb, D, D);
    end
    total++;
    if ({rd, oe} !== {ed, eo}) begin bad++; $display("FAIL wr_data_hold got=%h/%b exp=%h/%b", rd, oe, ed, eo); end
    step();
    total++;
    if (wr_cnt !== m_wr || busy !== 1'b0) begin bad++; $display("FAIL wr_count got=%0d exp=%0d busy=%b", wr_cnt, m_wr, busy); end
    mdl_do(32'h40, '0, 1'b0, ed, eo);
    xact(32'h40, '0, 1'b0, 0, we, lat, nb, rd, oe);
    total++;
    if ({rd, oe, lat} !== {ed, eo, 32'(D)}) begin bad++; $display("FAIL rd_line got=%h/%b lat=%0d exp=%h/%b", rd, oe, lat, ed, eo); end
    step();
    total++;
    if (rd_cnt !== m_rd) begin bad++; $display("FAIL rd_count got=%0d exp=%0d", rd_cnt, m_rd); end
  endtask

  task automatic test_back_to_back();
    int we, lat, nb; logic [255:0] rd, ed, b; logic oe, eo;
    b = rnd256();
    mdl_do(32'h20, b, 1'b1, ed, eo);
    xact(32'h20, b, 1'b1, 1, we, lat, nb, rd, oe);
    known[1] = 1;
    step();
    total++;
    if ({busy, wr_cnt} !== {1'b0, m_wr}) begin bad++; $display("FAIL b2b_gap busy=%b wr=%0d exp wr=%0d", busy, wr_cnt, m_wr); end
    mdl_do(32'h40, '0, 1'b0, ed, eo);
    xact(32'h40, '0, 1'b0, 0, we, lat, nb, rd, oe);
    total++;
    if ({we, lat} !== {32'sd1, 32'(D)}) begin bad++; $display("FAIL b2b_accept wait=%0d lat=%0d exp 1/%0d", we, lat, D); end
    total++;
    if (rd !== ed) begin bad++; $display("FAIL b2b_data got=%h exp=%h", rd, ed); end
    step();
    mdl_do(32'h20, '0, 1'b0, ed, eo);
    xact(32'h20, '0, 1'b0, 0, we, lat, nb, rd, oe);
    total++;
    if (rd !== ed) begin bad++; $display("FAIL b2b_line1 got=%h exp=%h", rd, ed); end
    step();
  endtask

  task automatic test_offset();
    int we, lat, nb; logic [255:0] rd, ed; logic oe, eo;
    mdl_do(32'h5F, '0, 1'b0, ed, eo);
    xact(32'h5F, '0, 1'b0, 0, we, lat, nb, rd, oe);
    total++;
    if ({rd, oe} !== {ed, eo}) begin bad++; $display("FAIL offset_ignore got=%h/%b exp=%h/%b", rd, oe, ed, eo); end
    step();
  endtask

  task automatic test_oob();
    int we, lat, nb; logic [255:0] rd, ed; logic oe, eo;
    mdl_do(32'h8000, '0, 1'b0, ed, eo);
    xact(32'h8000, '0, 1'b0, 0, we, lat, nb, rd, oe);
    total++;
    if ({rd, oe} !== {256'h0, 1'b1} || {rd, oe} !== {ed, eo}) begin
      bad++; $display("FAIL oob_read got=%h/%b exp=0/1", rd, oe);
    end
    step();
    total++;
    if (rd_cnt !== m_rd) begin bad++; $display("FAIL oob_rd_count got=%0d exp=%0d", rd_cnt, m_rd); end
    mdl_do(32'h0001_0000, ~d0_line, 1'b1, ed, eo);
    xact(32'h0001_0000, ~d0_line, 1'b1, 0, we, lat, nb, rd, oe);
    total++;
    if (oe !== 1'b1 || eo !== 1'b1) begin bad++; $display("FAIL oob_write_flag got=%b exp=1", oe); end
    step();
    total++;
    if (wr_cnt !== m_wr) begin bad++; $display("FAIL oob_wr_count got=%0d exp=%0d", wr_cnt, m_wr); end
    mdl_do(32'h0, '0, 1'b0, ed, eo);
    xact(32'h0, '0, 1'b0, 0, we, lat, nb, rd, oe);
    total++;
    if ({rd, oe} !== {ed, eo} || rd !== d0_line) begin bad++; $display("FAIL oob_write_dropped got=%h exp=%h", rd, d0_line); end
    step();
  endtask

  task automatic test_mid_reset();
    int we, lat, nb; logic [255:0] rd, ed; logic oe, eo; bit seen;
    p_line = rnd256();
    mdl_do(32'h60, p_line, 1'b1, ed, eo);
    xact(32'h60, p_line, 1'b1, 0, we, lat, nb, rd, oe);
    known[3] = 1;
    step();
    addr = 32'h60; wdata = ~p_line; rw = 1'b1; valid = 1'b1;
    step();
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL midrst_accept busy=%b exp=1", busy); end
    step();
    rst = 1'b1; valid = 1'b0; rw = 1'b0;
    step();
    total++;
    if ({busy, ready, oob, rd_cnt, wr_cnt, mem_data} !== '0) begin
      bad++; $display("FAIL midrst_state busy=%b ready=%b oob=%b rd=%0d wr=%0d data=%h", busy, ready, oob, rd_cnt, wr_cnt, mem_data);
    end
    rst = 1'b0;
    m_rd = '0; m_wr = '0; m_data = '0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin step(); if (ready) seen = 1; end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL midrst_no_ready got=1 exp=0"); end
    mdl_do(32'h60, '0, 1'b0, ed, eo);
    xact(32'h60, '0, 1'b0, 0, we, lat, nb, rd, oe);
    total++;
    if (rd !== ed || rd !== p_line) begin bad++; $display("FAIL midrst_line got=%h exp=%h", rd, p_line); end
    step();
    total++;
    if ({rd_cnt, wr_cnt} !== {m_rd, m_wr}) begin bad++; $display("FAIL midrst_counts rd=%0d wr=%0d exp %0d/%0d", rd_cnt, wr_cnt, m_rd, m_wr); end
  endtask

  task automatic test_random();
    int we, lat, nb, idx; logic [255:0] rd, ed, d; logic oe, eo, w; logic [31:0] a; bit hold;
    for (int k = 0; k < 40; k++) begin
      w = 1'($urandom_range(0, 1));
      hold = bit'($urandom_range(0, 1));
      d = rnd256();
      if ($urandom_range(0, 7) == 0) begin
        a = $urandom();
        if (a < 32'h8000) a = a + 32'h8000;
      end else begin
        idx = $urandom_range(0, 15);
        if (!w) while (!known[idx]) idx = $urandom_range(0, 15);
        if (w) known[idx] = 1;
        a = 32'(idx * 32 + $urandom_range(0, 31));
      end
      mdl_do(a, d, w, ed, eo);
      xact(a, d, w, hold, we, lat, nb, rd, oe);
      total++;
      if ({we, lat, nb} !== {32'sd1, 32'(D), 32'(D)}) begin
        bad++; $display("FAIL rnd_timing k=%0d wait=%0d lat=%0d busy=%0d", k, we, lat, nb);
      end
      total++;
      if ({rd, oe} !== {ed, eo}) begin bad++; $display("FAIL rnd_resp k=%0d a=%h got=%h/%b exp=%h/%b", k, a, rd, oe, ed, eo); end
      step();
      total++;
      if ({rd_cnt, wr_cnt} !== {m_rd, m_wr}) begin bad++; $display("FAIL rnd_counts k=%0d rd=%0d wr=%0d exp %0d/%0d", k, rd_cnt, wr_cnt, m_rd, m_wr); end
      valid = 1'b0;
    end
  endtask

  task automatic test_delay_builds();
    int r1, r100, b1, b100;
    x_rst = 1'b0;
    step();
    x_addr = 32'h100; x_wdata = rnd256(); x_rw = 1'b1; x_valid1 = 1'b1; x_valid100 = 1'b1;
    r1 = -1; r100 = -1; b1 = 0; b100 = 0;
    for (int i = 1; i <= 130; i++) begin
      step();
      if (d1_busy) b1++;
      if (d100_busy) b100++;
      if (d1_ready && r1 < 0) begin r1 = i; x_valid1 = 1'b0; end
      if (d100_ready && r100 < 0) begin r100 = i; x_valid100 = 1'b0; end
    end
    total++;
    if ({r1, b1} !== {32'sd1, 32'sd1}) begin bad++; $display("FAIL delay1 ready_at=%0d busy=%0d exp 1/1", r1, b1); end
    total++;
    if ({r100, b100} !== {32'sd100, 32'sd100}) begin bad++; $display("FAIL delay100 ready_at=%0d busy=%0d exp 100/100", r100, b100); end
    total++;
    if ({d1_wr, d100_wr, d1_rd, d100_rd, d1_oob, d100_oob, d100_data} !== {32'd1, 32'd1, 64'd0, 2'b00, 256'h0}) begin
      bad++; $display("FAIL delay_counts wr1=%0d wr100=%0d rd1=%0d rd100=%0d", d1_wr, d100_wr, d1_rd, d100_rd);
    end
    x_rw = 1'b0; x_valid1 = 1'b1;
    step();
    x_valid1 = 1'b0;
    total++;
    if ({d1_ready, d1_data} !== {1'b1, x_wdata}) begin bad++; $display("FAIL delay1_read ready=%b got=%h exp=%h", d1_ready, d1_data, x_wdata); end
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; rw = 1'b0; addr = '0; wdata = '0;
    x_rst = 1'b1; x_rw = 1'b0; x_valid1 = 1'b0; x_valid100 = 1'b0; x_addr = '0; x_wdata = '0;
    m_rd = '0; m_wr = '0; m_data = '0;
    for (int i = 0; i < 16; i++) known[i] = 0;
    step(); step();
    test_reset();
    test_write_read();
    test_back_to_back();
    test_offset();
    test_oob();
    test_mid_reset();
    test_random();
    test_delay_builds();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
